// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card init sequencer: power-up idle, CMD0, CMD8, CMD55/ACMD41 loop
// and CMD58, driving the sd_controller command port and reporting ready/error.
module sd_init_sequencer #(
  parameter int unsigned POWERUP_CYCLES = 80,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES    = 255,
  parameter int unsigned NRESP_W        = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_start,
  output logic               busy,
  output logic               ready,
  output logic               error,
  output logic [2:0]         err_code,
  output logic               sdhc,
  output logic [5:0]         sd_cmd,
  output logic [31:0]        sd_arg,
  output logic [6:0]         sd_crc,
  output logic [NRESP_W-1:0] sd_nresponse,
  output logic               sd_start,
  input  logic               sd_done,
  input  logic [7:0]         rsp_r1,
  input  logic [31:0]        rsp_tail
);

  localparam int unsigned CNT_MAX = (POWERUP_CYCLES > TIMEOUT_CYCLES) ? POWERUP_CYCLES
                                                                       : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned ATT_W   = 8;

  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_CMD0    = 3'd2;
  localparam logic [2:0] ERR_CMD8    = 3'd3;
  localparam logic [2:0] ERR_ACMD41  = 3'd4;
  localparam logic [2:0] ERR_CMD58   = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD58, S_READY, S_ERROR
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [ATT_W-1:0]   attempts, attempts_d;
  logic               v2, v2_d;
  logic [2:0]         err_code_d;
  logic               sdhc_d;
  logic [5:0]         sd_cmd_d;
  logic [31:0]        sd_arg_d;
  logic [6:0]         sd_crc_d;
  logic [NRESP_W-1:0] sd_nresponse_d;
  logic               sd_start_d;
  logic [2:0]         fail;

  // Only the echo pattern and the CCS bit of the response tail matter here.
  logic tail_unused;
  assign tail_unused = ^{rsp_tail[31], rsp_tail[29:12]};

  // Next-state logic; in a command state a low sd_start means the WAIT phase.
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    attempts_d     = attempts;
    v2_d           = v2;
    err_code_d     = err_code;
    sdhc_d         = sdhc;
    sd_cmd_d       = sd_cmd;
    sd_arg_d       = sd_arg;
    sd_crc_d       = sd_crc;
    sd_nresponse_d = sd_nresponse;
    sd_start_d     = 1'b0;
    fail           = 3'd0;

    unique case (state)
      S_IDLE, S_READY, S_ERROR: begin
        if (init_start) begin
          state_d    = S_PWRUP;
          cnt_d      = '0;
          attempts_d = '0;
          v2_d       = 1'b0;
          err_code_d = 3'd0;
          sdhc_d     = 1'b0;
        end
      end
      S_PWRUP: begin
        if (cnt == CNT_W'(POWERUP_CYCLES - 1)) state_d = S_CMD0;
        else                                   cnt_d   = cnt + CNT_W'(1);
      end
      default: begin
        cnt_d = cnt + CNT_W'(1);
        if (!sd_start) begin
          if (sd_done) begin
            case (state)
              S_CMD0: begin
                if (rsp_r1 == 8'h01) state_d = S_CMD8;
                else                 fail    = ERR_CMD0;
              end
              S_CMD8: begin
                if (rsp_r1 == 8'h01 && rsp_tail[11:0] == 12'h1AA) begin
                  v2_d    = 1'b1;
                  state_d = S_CMD55;
                end else if (rsp_r1 == 8'h05) begin
                  v2_d    = 1'b0;
                  state_d = S_CMD55;
                end else begin
                  fail = ERR_CMD8;
                end
              end
              S_CMD55: begin
                if (rsp_r1 == 8'h00 || rsp_r1 == 8'h01) state_d = S_ACMD41;
                else                                    fail    = ERR_ACMD41;
              end
              S_ACMD41: begin
                if (rsp_r1 == 8'h00) begin
                  state_d = v2 ? S_CMD58 : S_READY;
                  if (!v2) sdhc_d = 1'b0;
                end else if (rsp_r1 == 8'h01 && attempts < ATT_W'(MAX_RETRIES)) begin
                  state_d = S_CMD55;
                end else begin
                  fail = ERR_ACMD41;
                end
              end
              S_CMD58: begin
                if (rsp_r1 == 8'h00) begin
                  sdhc_d  = rsp_tail[30];
                  state_d = S_READY;
                end else begin
                  fail = ERR_CMD58;
                end
              end
              default: ;
            endcase
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            fail = ERR_TIMEOUT;
          end
        end
      end
    endcase

    if (fail != 3'd0) begin
      state_d    = S_ERROR;
      err_code_d = fail;
    end

    // Entering a command state is the ISSUE cycle: strobe and load the command.
    if (state_d != state && state_d inside {S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD58}) begin
      sd_start_d     = 1'b1;
      cnt_d          = '0;
      sd_arg_d       = 32'h0000_0000;
      sd_crc_d       = 7'h7F;
      sd_nresponse_d = NRESP_W'(1);
      case (state_d)
        S_CMD0: begin
          sd_cmd_d = 6'd0;
          sd_crc_d = 7'h4A;
        end
        S_CMD8: begin
          sd_cmd_d       = 6'd8;
          sd_arg_d       = 32'h0000_01AA;
          sd_crc_d       = 7'h43;
          sd_nresponse_d = NRESP_W'(5);
        end
        S_CMD55: sd_cmd_d = 6'd55;
        S_ACMD41: begin
          sd_cmd_d   = 6'd41;
          sd_arg_d   = v2_d ? 32'h4000_0000 : 32'h0000_0000;
          attempts_d = attempts + ATT_W'(1);
        end
        S_CMD58: begin
          sd_cmd_d       = 6'd58;
          sd_nresponse_d = NRESP_W'(5);
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      attempts     <= '0;
      v2           <= 1'b0;
      busy         <= 1'b0;
      ready        <= 1'b0;
      error        <= 1'b0;
      err_code     <= 3'd0;
      sdhc         <= 1'b0;
      sd_cmd       <= 6'd0;
      sd_arg       <= 32'h0000_0000;
      sd_crc       <= 7'h00;
      sd_nresponse <= '0;
      sd_start     <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      attempts     <= attempts_d;
      v2           <= v2_d;
      busy         <= state_d inside {S_PWRUP, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD58};
      ready        <= (state_d == S_READY);
      error        <= (state_d == S_ERROR);
      err_code     <= err_code_d;
      sdhc         <= sdhc_d;
      sd_cmd       <= sd_cmd_d;
      sd_arg       <= sd_arg_d;
      sd_crc       <= sd_crc_d;
      sd_nresponse <= sd_nresponse_d;
      sd_start     <= sd_start_d;
    end
  end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Bench for sd_init_sequencer: scripted SD card model with a scoreboard of
// expected commands, a scenario table, and hand-written timing/reset sequences.
`timescale 1ns/1ps
module tb_sd_init_sequencer;

  localparam int unsigned P  = 8;
  localparam int unsigned T  = 16;
  localparam int unsigned R  = 3;
  localparam int unsigned NW = 4;
  localparam logic [31:0] HCS = 32'h4000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_start;
  logic          busy, ready, error, sdhc, sd_start;
  logic [2:0]    err_code;
  logic [5:0]    sd_cmd;
  logic [31:0]   sd_arg;
  logic [6:0]    sd_crc;
  logic [NW-1:0] sd_nresponse;
  logic          sd_done;
  logic [7:0]    rsp_r1;
  logic [31:0]   rsp_tail;

  sd_init_sequencer #(
    .POWERUP_CYCLES(P), .TIMEOUT_CYCLES(T), .MAX_RETRIES(R), .NRESP_W(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start), .busy(busy), .ready(ready),
    .error(error), .err_code(err_code), .sdhc(sdhc), .sd_cmd(sd_cmd), .sd_arg(sd_arg),
    .sd_crc(sd_crc), .sd_nresponse(sd_nresponse), .sd_start(sd_start),
    .sd_done(sd_done), .rsp_r1(rsp_r1), .rsp_tail(rsp_tail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          scn;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [7:0]  r1;
    logic [31:0] tail;
    int          delay;   // cycles from sd_start to sd_done; <= 0 means never answer
  } step_t;

  typedef struct {
    string      name;
    logic       rdy;
    logic       err;
    logic [2:0] code;
    logic       hc;
  } scn_t;

  step_t steps[$];
  step_t exp_q[$];
  scn_t  scns[$];

  int total = 0;
  int bad = 0;
  int n_starts = 0;
  int last_start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] exp_crc(input logic [5:0] c);
    case (c)
      6'd0:    return 7'h4A;
      6'd8:    return 7'h43;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [NW-1:0] exp_nresp(input logic [5:0] c);
    return (c == 6'd8 || c == 6'd58) ? NW'(5) : NW'(1);
  endfunction

  task automatic add_step(input int scn, input int cmd, input logic [31:0] arg,
                          input logic [7:0] r1, input logic [31:0] tail, input int delay);
    step_t s;
    s.scn = scn; s.cmd = 6'(cmd); s.arg = arg; s.r1 = r1; s.tail = tail; s.delay = delay;
    steps.push_back(s);
  endtask

  task automatic v2_prefix(input int scn);
    add_step(scn, 0, 32'h0, 8'h01, 32'h0, 2);
    add_step(scn, 8, 32'h0000_01AA, 8'h01, 32'h0000_01AA, 2);
  endtask

  task automatic load_scn(input int id, output int n);
    n = 0;
    foreach (steps[k]) if (steps[k].scn == id) begin
      exp_q.push_back(steps[k]);
      n++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(output int c0);
    c0 = cyc;
    init_start = 1'b1;
    @(posedge clk); #1;
    init_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (!busy && (ready || error)) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int k;
    for (k = 0; k < budget && n_starts < target; k++) begin @(posedge clk); #1; end
    check(name, 32'(n_starts), 32'(target));
  endtask

  // Card model: pops the expected command on each sd_start and answers it.
  initial begin : card
    step_t st;
    bit skip;
    skip = 1'b0;
    sd_done = 1'b0; rsp_r1 = 8'hFF; rsp_tail = 32'hFFFF_FFFF;
    forever begin
      if (!skip) begin @(posedge clk); #1; end
      skip = 1'b0;
      if (sd_start === 1'b1) begin
        n_starts++;
        last_start_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_start: got cmd %0d expected no command", sd_cmd);
        end else begin
          st = exp_q.pop_front();
          check("cmd", 32'(sd_cmd), 32'(st.cmd));
          check("arg", sd_arg, st.arg);
          check("crc", 32'(sd_crc), 32'(exp_crc(st.cmd)));
          check("nresp", 32'(sd_nresponse), 32'(exp_nresp(st.cmd)));
          if (st.delay > 0) begin
            repeat (st.delay) @(posedge clk);
            #1;
            check("cmd_held", 32'(sd_cmd), 32'(st.cmd));
            sd_done = 1'b1; rsp_r1 = st.r1; rsp_tail = st.tail;
            @(posedge clk); #1;
            sd_done = 1'b0; rsp_r1 = 8'hFF; rsp_tail = 32'hFFFF_FFFF;
            skip = 1'b1;
          end
        end
      end
    end
  end

  task automatic run_scn(input int i);
    int n, base, c0;
    logic ok;
    load_scn(i, n);
    base = n_starts;
    pulse_start(c0);
    check({scns[i].name, "/busy_at_start"}, 32'(busy), 32'd1);
    check({scns[i].name, "/cleared_at_start"}, {28'd0, ready, error, err_code == 3'd0, sdhc},
          32'b0010);
    wait_end(3000, ok);
    check({scns[i].name, "/finished"}, 32'(ok), 32'd1);
    tick(6);
    check({scns[i].name, "/ready"}, 32'(ready), 32'(scns[i].rdy));
    check({scns[i].name, "/error"}, 32'(error), 32'(scns[i].err));
    check({scns[i].name, "/err_code"}, 32'(err_code), 32'(scns[i].code));
    check({scns[i].name, "/sdhc"}, 32'(sdhc), 32'(scns[i].hc));
    check({scns[i].name, "/busy"}, 32'(busy), 32'd0);
    check({scns[i].name, "/starts"}, 32'(n_starts - base), 32'(n));
    check({scns[i].name, "/script_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, base, c0, s_cyc, k;
    logic ok;
    rst_n = 1'b1; init_start = 1'b0;

    // Scenario table: response scripts plus the final state each must reach.
    v2_prefix(0);
    for (int a = 0; a < 3; a++) begin
      add_step(0, 55, 32'h0, 8'h01, 32'h0, 2);
      add_step(0, 41, HCS, (a == 2) ? 8'h00 : 8'h01, 32'h0, 2);
    end
    add_step(0, 58, 32'h0, 8'h00, 32'hC0FF_8000, 2);
    scns.push_back('{"nominal_sdhc", 1'b1, 1'b0, 3'd0, 1'b1});

    add_step(1, 0, 32'h0, 8'h01, 32'h0, 2);
    add_step(1, 8, 32'h0000_01AA, 8'h05, 32'h0, 3);
    add_step(1, 55, 32'h0, 8'h01, 32'h0, 2);
    add_step(1, 41, 32'h0, 8'h00, 32'h0, 1);
    scns.push_back('{"v1_card", 1'b1, 1'b0, 3'd0, 1'b0});

    add_step(2, 0, 32'h0, 8'hFF, 32'h0, 2);
    scns.push_back('{"cmd0_bad", 1'b0, 1'b1, 3'd2, 1'b0});

    v2_prefix(3);
    for (int a = 0; a < 3; a++) begin
      add_step(3, 55, 32'h0, 8'h01, 32'h0, 2);
      add_step(3, 41, HCS, 8'h01, 32'h0, 2);
    end
    scns.push_back('{"retries_out", 1'b0, 1'b1, 3'd4, 1'b0});

    add_step(4, 0, 32'h0, 8'h01, 32'h0, 2);
    add_step(4, 8, 32'h0000_01AA, 8'h01, 32'h0000_01AB, 2);
    scns.push_back('{"cmd8_echo", 1'b0, 1'b1, 3'd3, 1'b0});

    v2_prefix(5);
    add_step(5, 55, 32'h0, 8'h00, 32'h0, 2);
    add_step(5, 41, HCS, 8'h00, 32'h0, 2);
    add_step(5, 58, 32'h0, 8'h05, 32'hC0FF_8000, 2);
    scns.push_back('{"cmd58_bad", 1'b0, 1'b1, 3'd5, 1'b0});

    add_step(6, 0, 32'h0, 8'h01, 32'h0, 2);
    add_step(6, 8, 32'h0000_01AA, 8'h01, 32'h0000_01AA, T - 1);
    add_step(6, 55, 32'h0, 8'h01, 32'h0, T - 1);
    add_step(6, 41, HCS, 8'h00, 32'h0, 1);
    add_step(6, 58, 32'h0, 8'h00, 32'h80FF_8000, 3);
    scns.push_back('{"sdsc_late_done", 1'b1, 1'b0, 3'd0, 1'b0});

    v2_prefix(7);
    add_step(7, 55, 32'h0, 8'h04, 32'h0, 2);
    scns.push_back('{"cmd55_bad", 1'b0, 1'b1, 3'd4, 1'b0});

    // Scripts for the hand-written sequences.
    add_step(100, 0, 32'h0, 8'h01, 32'h0, 2);
    add_step(100, 8, 32'h0000_01AA, 8'h01, 32'h0000_01AA, 0);
    v2_prefix(101);
    add_step(101, 55, 32'h0, 8'h01, 32'h0, 2);
    add_step(101, 41, HCS, 8'h01, 32'h0, 0);

    #2 rst_n = 1'b0;
    tick(3);
    check("reset/outputs",
          {busy, ready, error, sdhc, sd_start, err_code, sd_cmd, sd_crc, 4'(sd_nresponse)},
          32'd0);
    check("reset/sd_arg", sd_arg, 32'd0);
    rst_n = 1'b1;
    tick(2);

    foreach (scns[i]) run_scn(i);

    // Timeout: CMD8 never answered; error must rise exactly T cycles after its strobe.
    load_scn(100, n);
    base = n_starts;
    pulse_start(c0);
    wait_starts(base + 2, 200, "timeout/cmd8_issued");
    s_cyc = last_start_cyc;
    for (k = 0; k < 60 && !error; k++) tick(1);
    check("timeout/latency", 32'(cyc - s_cyc), 32'(T));
    check("timeout/err_code", 32'(err_code), 32'd1);
    check("timeout/busy", 32'(busy), 32'd0);
    tick(4);
    check("timeout/starts", 32'(n_starts - base), 32'd2);
    exp_q.delete();

    // Asynchronous reset during ACMD41 WAIT.
    load_scn(101, n);
    base = n_starts;
    pulse_start(c0);
    wait_starts(base + 4, 300, "rst/acmd41_issued");
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("rst/outputs",
          {busy, ready, error, sdhc, sd_start, err_code, sd_cmd, sd_crc, 4'(sd_nresponse)},
          32'd0);
    check("rst/sd_arg", sd_arg, 32'd0);
    tick(3);
    check("rst/no_start", 32'(n_starts - base), 32'd4);
    @(negedge clk) rst_n = 1'b1;
    tick(2);

    // Fresh start with extra init_start pulses while busy; they must be ignored.
    load_scn(1, n);
    base = n_starts;
    pulse_start(c0);
    tick(3);
    check("restart/busy_in_pwrup", 32'(busy), 32'd1);
    pulse_start(k);
    wait_starts(base + 1, 100, "restart/cmd0_issued");
    check("restart/cmd0_cycle", 32'(last_start_cyc), 32'(c0 + 1 + int'(P)));
    wait_starts(base + 2, 100, "restart/cmd8_issued");
    pulse_start(k);
    wait_end(1000, ok);
    check("restart/finished", 32'(ok), 32'd1);
    tick(6);
    check("restart/ready", 32'(ready), 32'd1);
    check("restart/error", 32'(error), 32'd0);
    check("restart/sdhc", 32'(sdhc), 32'd0);
    check("restart/starts", 32'(n_starts - base), 32'(n));
    check("restart/script_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
